// File: rtl/regbank_pkg.sv
// Shared constants, state encoding and lane helpers for the register-bank
// operand collector and its scoreboard.
package regbank_pkg;

  localparam int NLANES_DEF = 8;
  localparam int NREGS_DEF  = 64;
  localparam int DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } oc_state_e;

  function automatic int aw(input int nregs);
    return $clog2(nregs);
  endfunction

  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/regbank_operand_collector_if.sv
// Issue, operand and writeback bundles of the operand collector.
// master = core side, slave = collector.
interface regbank_oc_if
  import regbank_pkg::*;
#(
  parameter int NLANES = NLANES_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW     = aw(NREGS_DEF)
) ();

  logic                     iss_valid;
  logic                     iss_ready;
  logic [AW-1:0]            iss_src0;
  logic [AW-1:0]            iss_src1;
  logic                     iss_src1_en;
  logic [AW-1:0]            iss_dst;
  logic                     iss_dst_en;
  logic [NLANES-1:0]        iss_mask;

  logic                     op_valid;
  logic                     op_ready;
  logic [NLANES*DATA_W-1:0] op_a;
  logic [NLANES*DATA_W-1:0] op_b;
  logic [NLANES-1:0]        op_mask;

  logic                     wb_valid;
  logic [AW-1:0]            wb_addr;
  logic [NLANES-1:0]        wb_mask;
  logic [NLANES*DATA_W-1:0] wb_data;
  logic                     wb_last;

  modport master (
    output iss_valid, iss_src0, iss_src1, iss_src1_en,
    output iss_dst, iss_dst_en, iss_mask,
    input  iss_ready,
    input  op_valid, op_a, op_b, op_mask,
    output op_ready,
    output wb_valid, wb_addr, wb_mask, wb_data, wb_last
  );

  modport slave (
    input  iss_valid, iss_src0, iss_src1, iss_src1_en,
    input  iss_dst, iss_dst_en, iss_mask,
    output iss_ready,
    output op_valid, op_a, op_b, op_mask,
    input  op_ready,
    input  wb_valid, wb_addr, wb_mask, wb_data, wb_last
  );

endinterface

// File: rtl/regbank_scoreboard.sv
// Pending-write scoreboard, one bit per register, three lookup ports.
// REGBANK_EARLY_WAKEUP_EN lets a same-cycle wb_last clear hide the bit.
module regbank_scoreboard
  import regbank_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = aw(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] lk_addr_0,
  input  logic [AW-1:0] lk_addr_1,
  input  logic [AW-1:0] lk_addr_2,
  output logic          lk_hit_0,
  output logic          lk_hit_1,
  output logic          lk_hit_2
);

  logic [NREGS-1:0] sb_q;
  logic [NREGS-1:0] sb_d;
  logic [NREGS-1:0] sb_view;

  // set is applied last so it wins over a same-bit clear
  always_comb begin
    sb_d = sb_q;
    if (clr_en) sb_d[clr_addr] = 1'b0;
    if (set_en) sb_d[set_addr] = 1'b1;
  end

`ifdef REGBANK_EARLY_WAKEUP_EN
  always_comb begin
    sb_view = sb_q;
    if (clr_en) sb_view[clr_addr] = 1'b0;
  end
`else
  assign sb_view = sb_q;
`endif

  assign lk_hit_0 = sb_view[lk_addr_0];
  assign lk_hit_1 = sb_view[lk_addr_1];
  assign lk_hit_2 = sb_view[lk_addr_2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_q <= '0;
    else        sb_q <= sb_d;
  end

endmodule

// File: rtl/regbank_operand_collector.sv
// Operand collector: issue -> bank read -> operand hold, plus writeback.
// Build with REGBANK_EARLY_WAKEUP_EN to wake dependents on wb_last.
module regbank_operand_collector
  import regbank_pkg::*;
#(
  parameter  int NLANES = NLANES_DEF,
  parameter  int NREGS  = NREGS_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  localparam int AW     = aw(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  regbank_oc_if.slave              io,
  output logic [NLANES-1:0]        read_en_0,
  output logic [NLANES-1:0]        read_en_1,
  output logic [AW-1:0]            raddr_0,
  output logic [AW-1:0]            raddr_1,
  input  logic [NLANES*DATA_W-1:0] rdata_0,
  input  logic [NLANES*DATA_W-1:0] rdata_1,
  output logic [NLANES-1:0]        write_en,
  output logic [AW-1:0]            waddr,
  output logic [NLANES*DATA_W-1:0] wdata
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_READ = READ;
  localparam logic [1:0] ST_HOLD = HOLD;

  logic [1:0]               state_q;
  logic [1:0]               state_d;
  logic [AW-1:0]            src0_q;
  logic [AW-1:0]            src1_q;
  logic                     src1_en_q;
  logic [NLANES-1:0]        mask_q;
  logic [NLANES*DATA_W-1:0] op_a_q;
  logic [NLANES*DATA_W-1:0] op_b_q;
  logic [NLANES*DATA_W-1:0] op_a_d;
  logic [NLANES*DATA_W-1:0] op_b_d;
  logic [NLANES-1:0]        op_mask_q;
  logic                     op_valid_q;
  logic                     hit0;
  logic                     hit1;
  logic                     hit2;
  logic                     hazard;
  logic                     iss_fire;
  logic                     st_idle;
  logic                     st_read;
  logic                     st_hold;

  assign st_idle = (state_q == ST_IDLE);
  assign st_read = (state_q == ST_READ);
  assign st_hold = (state_q == ST_HOLD);

  regbank_scoreboard #(
    .NREGS (NREGS)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (iss_fire & io.iss_dst_en),
    .set_addr  (io.iss_dst),
    .clr_en    (io.wb_valid & io.wb_last),
    .clr_addr  (io.wb_addr),
    .lk_addr_0 (io.iss_src0),
    .lk_addr_1 (io.iss_src1),
    .lk_addr_2 (io.iss_dst),
    .lk_hit_0  (hit0),
    .lk_hit_1  (hit1),
    .lk_hit_2  (hit2)
  );

  assign hazard = hit0
                | (io.iss_src1_en & hit1)
                | (io.iss_dst_en & hit2);

  assign io.iss_ready = st_idle & ~hazard;
  assign iss_fire     = io.iss_valid & io.iss_ready;

  assign read_en_0 = st_read ? mask_q : '0;
  assign read_en_1 = (st_read & src1_en_q) ? mask_q : '0;
  assign raddr_0   = st_read ? src0_q : '0;
  assign raddr_1   = st_read ? src1_q : '0;

  assign write_en = (io.wb_valid & rst_n) ? io.wb_mask : '0;
  assign waddr    = io.wb_addr;
  assign wdata    = io.wb_data;

  assign io.op_valid = op_valid_q;
  assign io.op_a     = op_a_q;
  assign io.op_b     = op_b_q;
  assign io.op_mask  = op_mask_q;

  // inactive lanes and an unused source 1 present as zero
  always_comb begin
    op_a_d = '0;
    op_b_d = '0;
    for (int l = 0; l < NLANES; l++) begin
      if (mask_q[l]) begin
        op_a_d[lane_lo(l, DATA_W) +: DATA_W] =
          rdata_0[lane_lo(l, DATA_W) +: DATA_W];
        if (src1_en_q)
          op_b_d[lane_lo(l, DATA_W) +: DATA_W] =
            rdata_1[lane_lo(l, DATA_W) +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      st_idle: if (iss_fire) state_d = ST_READ;
      st_read: state_d = ST_HOLD;
      st_hold: if (io.op_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      src0_q     <= '0;
      src1_q     <= '0;
      src1_en_q  <= 1'b0;
      mask_q     <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_mask_q  <= '0;
      op_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (iss_fire) begin
        src0_q    <= io.iss_src0;
        src1_q    <= io.iss_src1;
        src1_en_q <= io.iss_src1_en;
        mask_q    <= io.iss_mask;
      end
      if (st_read) begin
        op_a_q     <= op_a_d;
        op_b_q     <= op_b_d;
        op_mask_q  <= mask_q;
        op_valid_q <= 1'b1;
      end else if (st_hold & io.op_ready) begin
        op_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regbank_operand_collector.sv
// Scoreboard bench for regbank_operand_collector with a behavioural
// 2R/1W register bank attached to the bank ports.
module tb_regbank_operand_collector;

  localparam int NL = 8;
  localparam int NR = 64;
  localparam int DW = 64;
  localparam int AW = 6;
  localparam int W  = NL * DW;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [NL-1:0] m;
    int            acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regbank_oc_if #(.NLANES(NL), .DATA_W(DW), .AW(AW)) io ();

  logic [NL-1:0] read_en_0, read_en_1, write_en;
  logic [AW-1:0] raddr_0, raddr_1, waddr;
  logic [W-1:0]  rdata_0, rdata_1, wdata;

  regbank_operand_collector #(
    .NLANES (NL),
    .NREGS  (NR),
    .DATA_W (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .io        (io),
    .read_en_0 (read_en_0),
    .read_en_1 (read_en_1),
    .raddr_0   (raddr_0),
    .raddr_1   (raddr_1),
    .rdata_0   (rdata_0),
    .rdata_1   (rdata_1),
    .write_en  (write_en),
    .waddr     (waddr),
    .wdata     (wdata)
  );

  logic [DW-1:0] bank   [NR][NL] = '{default: '0};
  logic [DW-1:0] shadow [NR][NL] = '{default: '0};

  always @(posedge clk)
    for (int l = 0; l < NL; l++)
      if (write_en[l]) bank[waddr][l] <= wdata[l*DW +: DW];

  always_comb begin
    rdata_0 = '0;
    rdata_1 = '0;
    for (int l = 0; l < NL; l++) begin
      rdata_0[l*DW +: DW] = read_en_0[l] ? bank[raddr_0][l] : 64'hBAD0_BAD0_BAD0_BAD0;
      rdata_1[l*DW +: DW] = read_en_1[l] ? bank[raddr_1][l] : 64'hBAD1_BAD1_BAD1_BAD1;
    end
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t q[$];
  bit   lat_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pat(input logic [15:0] tag);
    logic [W-1:0] v;
    for (int l = 0; l < NL; l++) v[l*DW +: DW] = {tag, 48'(l)};
    return v;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      lat_done = 1'b0;
    end else if (io.op_valid) begin
      if (q.size() == 0) begin
        chk("op_unexpected", W'(io.op_valid), '0);
      end else begin
        if (!lat_done) begin
          chk("op_latency", W'(cyc - q[0].acc), W'(2));
          lat_done = 1'b1;
        end
        if (io.op_ready) begin
          e = q.pop_front();
          chk("op_a", io.op_a, e.a);
          chk("op_b", io.op_b, e.b);
          chk("op_mask", W'(io.op_mask), W'(e.m));
          lat_done = 1'b0;
        end
      end
    end
  end

  task automatic do_wb(input logic [AW-1:0] a, input logic [NL-1:0] m,
                       input logic [W-1:0] d, input bit last);
    io.wb_valid = 1'b1;
    io.wb_addr  = a;
    io.wb_mask  = m;
    io.wb_data  = d;
    io.wb_last  = last;
    #1;
    chk("wb_write_en", W'(write_en), W'(m));
    chk("wb_waddr", W'(waddr), W'(a));
    @(posedge clk); #1;
    io.wb_valid = 1'b0;
    io.wb_last  = 1'b0;
    for (int l = 0; l < NL; l++)
      if (m[l]) shadow[a][l] = d[l*DW +: DW];
  endtask

  // returns one step into the READ cycle once accepted
  task automatic do_issue(input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                          input bit s1e, input logic [AW-1:0] d, input bit de,
                          input logic [NL-1:0] m);
    exp_t e;
    int   t = 0;
    io.iss_src0    = s0;
    io.iss_src1    = s1;
    io.iss_src1_en = s1e;
    io.iss_dst     = d;
    io.iss_dst_en  = de;
    io.iss_mask    = m;
    io.iss_valid   = 1'b1;
    #1;
    while (!io.iss_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!io.iss_ready) begin
      chk("iss_timeout", W'(io.iss_ready), W'(1));
    end else begin
      e.a = '0;
      e.b = '0;
      for (int l = 0; l < NL; l++) begin
        if (m[l]) e.a[l*DW +: DW] = shadow[s0][l];
        if (m[l] && s1e) e.b[l*DW +: DW] = shadow[s1][l];
      end
      e.m   = m;
      e.acc = cyc;
      q.push_back(e);
    end
    @(posedge clk); #1;
    io.iss_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((q.size() != 0 || io.op_valid) && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 20) chk("drain_timeout", W'(q.size()), '0);
  endtask

  initial begin
    exp_t         e;
    logic [W-1:0] v;
    io.iss_valid = 0; io.iss_src0 = 0; io.iss_src1 = 0; io.iss_src1_en = 0;
    io.iss_dst = 0; io.iss_dst_en = 0; io.iss_mask = 0; io.op_ready = 1;
    io.wb_valid = 0; io.wb_addr = 0; io.wb_mask = 0; io.wb_data = 0; io.wb_last = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_op_valid", W'(io.op_valid), '0);
    chk("rst_op_a", io.op_a, '0);
    chk("rst_op_mask", W'(io.op_mask), '0);
    chk("rst_read_en_0", W'(read_en_0), '0);
    chk("rst_write_en", W'(write_en), '0);
    chk("rst_raddr_0", W'(raddr_0), '0);
    rst_n = 1'b1;
    #1;
    chk("rst_iss_ready", W'(io.iss_ready), W'(1));

    // preload r5 and read it back on both ports
    do_wb(6'd5, 8'hFF, pat(16'hA5A5), 1'b1);
    do_issue(6'd5, 6'd5, 1'b1, 6'd0, 1'b0, 8'hFF);
    chk("read_en_1_full", W'(read_en_1), W'(8'hFF));
    wait_idle();

    // partial mask, source 1 unused
    do_issue(6'd5, 6'd7, 1'b0, 6'd0, 1'b0, 8'h0F);
    chk("mask_read_en_0", W'(read_en_0), W'(8'h0F));
    chk("mask_read_en_1", W'(read_en_1), '0);
    chk("mask_raddr_0", W'(raddr_0), W'(5));
    wait_idle();

    // RAW hazard on r9
    do_issue(6'd0, 6'd0, 1'b0, 6'd9, 1'b1, 8'hFF);
    wait_idle();
    io.iss_src0 = 6'd9; io.iss_src1_en = 0; io.iss_dst_en = 0;
    io.iss_mask = 8'hFF; io.iss_valid = 1;
    #1 chk("raw_block", W'(io.iss_ready), '0);
    @(posedge clk); #1 chk("raw_block_hold", W'(io.iss_ready), '0);
    io.wb_valid = 1; io.wb_last = 1; io.wb_addr = 6'd9;
    io.wb_mask = 8'hFF; io.wb_data = pat(16'h9999);
    #1;
`ifdef REGBANK_EARLY_WAKEUP_EN
    chk("raw_wake_early", W'(io.iss_ready), W'(1));
`else
    chk("raw_wait", W'(io.iss_ready), '0);
    @(posedge clk); #1;
    io.wb_valid = 0; io.wb_last = 0;
    #1 chk("raw_wake", W'(io.iss_ready), W'(1));
`endif
    e.a = pat(16'h9999); e.b = '0; e.m = 8'hFF; e.acc = cyc;
    q.push_back(e);
    @(posedge clk); #1;
    io.iss_valid = 0; io.wb_valid = 0; io.wb_last = 0;
    v = pat(16'h9999);
    for (int l = 0; l < NL; l++) shadow[9][l] = v[l*DW +: DW];
    wait_idle();

    // backpressure
    io.op_ready = 1'b0;
    do_issue(6'd5, 6'd5, 1'b1, 6'd0, 1'b0, 8'hFF);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_op_valid", W'(io.op_valid), W'(1));
      chk("bp_op_a", io.op_a, pat(16'hA5A5));
      chk("bp_iss_ready", W'(io.iss_ready), '0);
    end
    @(posedge clk); #1;
    io.op_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", W'(io.op_valid), '0);
    chk("bp_release_ready", W'(io.iss_ready), W'(1));

    // reset during READ drops the operation and the pending bit
    do_issue(6'd5, 6'd5, 1'b1, 6'd20, 1'b1, 8'hFF);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_read_en_0", W'(read_en_0), '0);
    chk("mid_rst_read_en_1", W'(read_en_1), '0);
    chk("mid_rst_op_valid", W'(io.op_valid), '0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    io.iss_src0 = 6'd20; io.iss_src1_en = 0; io.iss_dst_en = 0;
    #1 chk("post_rst_ready", W'(io.iss_ready), W'(1));
    do_issue(6'd20, 6'd0, 1'b0, 6'd0, 1'b0, 8'hFF);
    wait_idle();

    // sweep every register
    for (int r = 0; r < NR; r++) begin
      for (int k = 0; k < 100; k++) begin
        for (int l = 0; l < NL; l++) v[l*DW +: DW] = {$urandom, $urandom};
        do_wb(AW'(r), 8'hFF, v, 1'b1);
        do_issue(AW'(r), AW'(r), 1'b1, 6'd0, 1'b0, 8'hFF);
      end
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
